// File: rtl/fir_mac_seq.sv
// Time-multiplexed FIR filter: y[n] = sum_k h[k]*x[n-k], computed with one
// signed multiplier and one accumulator over NTAPS cycles per input sample.
// result_o / result_valid_o feed a downstream enable-gated holding register.
module fir_mac_seq #(
    parameter  int DATA_WIDTH = 16,
    parameter  int COEF_WIDTH = 16,
    parameter  int NTAPS      = 8,
    localparam int AW         = $clog2(NTAPS),
    localparam int OUT_W      = DATA_WIDTH + COEF_WIDTH + AW
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sample_valid_i,
    input  logic [DATA_WIDTH-1:0] sample_i,
    input  logic                  coef_we_i,
    input  logic [AW-1:0]         coef_addr_i,
    input  logic [COEF_WIDTH-1:0] coef_i,
    output logic                  busy_o,
    output logic [OUT_W-1:0]      result_o,
    output logic                  result_valid_o,
    output logic                  overrun_o
);

    localparam int PW = DATA_WIDTH + COEF_WIDTH;
    localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MAC  = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0] x_q [NTAPS];
    logic signed [DATA_WIDTH-1:0] x_d [NTAPS];
    logic signed [COEF_WIDTH-1:0] h_q [NTAPS];
    logic signed [COEF_WIDTH-1:0] h_d [NTAPS];
    logic signed [OUT_W-1:0]      acc_q, acc_d;
    logic        [AW-1:0]         idx_q, idx_d;
    logic signed [OUT_W-1:0]      result_q, result_d;
    logic                         result_valid_q, result_valid_d;
    logic                         overrun_q, overrun_d;

    logic signed [PW-1:0]         prod_s;
    logic signed [OUT_W-1:0]      prod_ext_s;
    logic                         coef_in_range_s;

    // Single shared multiplier: full-precision signed product of the current tap,
    // sign-extended so the accumulator can never overflow.
    assign prod_s          = h_q[idx_q] * x_q[idx_q];
    assign prod_ext_s      = {{AW{prod_s[PW-1]}}, prod_s};
    assign coef_in_range_s = (int'(coef_addr_i) < NTAPS);

    assign busy_o         = (state_q == ST_MAC);
    assign result_o       = result_q;
    assign result_valid_o = result_valid_q;
    assign overrun_o      = overrun_q;

    // Next-state and datapath update: sample acceptance, MAC stepping, coefficient writes.
    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        h_d            = h_q;
        acc_d          = acc_q;
        idx_d          = idx_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        overrun_d      = overrun_q;

        // Coefficients may only change between computations; a write in the
        // same cycle as a new sample lands before the first MAC step uses it.
        if (coef_we_i && (state_q == ST_IDLE) && coef_in_range_s) begin
            h_d[coef_addr_i] = coef_i;
        end else begin
            h_d = h_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (sample_valid_i) begin
                    x_d[0] = sample_i;
                    for (int k = 1; k < NTAPS; k++) begin
                        x_d[k] = x_q[k-1];
                    end
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_MAC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                // A sample arriving mid-computation is dropped and flagged.
                if (sample_valid_i) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
                acc_d = acc_q + prod_ext_s;
                if (idx_q == LAST_IDX) begin
                    result_d       = acc_q + prod_ext_s;
                    result_valid_d = 1'b1;
                    idx_d          = '0;
                    state_d        = ST_IDLE;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = ST_MAC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: delay line, coefficient bank, accumulator and outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k] <= '0;
                h_q[k] <= '0;
            end
            acc_q          <= '0;
            idx_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
                x_q[k] <= x_d[k];
                h_q[k] <= h_d[k];
            end
            acc_q          <= acc_d;
            idx_q          <= idx_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            overrun_q      <= overrun_d;
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Self-checking bench for fir_mac_seq: table-driven impulse vectors, a
// scoreboard fed from a behavioural FIR model, and hand-written corner cases.
module tb_fir_mac_seq;

    localparam int NT = 8;

    logic               clk_i;
    logic               rst_i;
    logic               sample_valid_i;
    logic signed [15:0] sample_i;
    logic               coef_we_i;
    logic [2:0]         coef_addr_i;
    logic signed [15:0] coef_i;
    logic               busy_o;
    logic signed [34:0] result_o;
    logic               result_valid_o;
    logic               overrun_o;

    fir_mac_seq dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .sample_valid_i (sample_valid_i),
        .sample_i       (sample_i),
        .coef_we_i      (coef_we_i),
        .coef_addr_i    (coef_addr_i),
        .coef_i         (coef_i),
        .busy_o         (busy_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .overrun_o      (overrun_o)
    );

    typedef struct {
        logic signed [15:0] sample;
        longint             expected;
    } vec_t;

    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc   = 0;
    int     last_pulse = 0;
    int     prev_pulse = 0;
    longint mx [NT];
    longint mh [NT];
    longint exp_q [$];
    int     stamp_q [$];
    vec_t   tbl [9];

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic longint model_y();
        longint s = 0;
        for (int k = 0; k < NT; k++) s += mh[k] * mx[k];
        return s;
    endfunction

    // Scoreboard: every result_valid_o pulse must match the oldest expectation.
    always @(negedge clk_i) begin
        if (rst_i && result_valid_o) begin
            prev_pulse = last_pulse;
            last_pulse = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: got result_valid_o=1 at cycle %0d required 0", cyc);
            end else begin
                check("scoreboard", result_o, exp_q.pop_front());
                check("latency", cyc - stamp_q.pop_front(), NT);
            end
        end
    end

    task automatic do_reset();
        #2 rst_i = 1'b0;
        #1;
        check("rst_busy", busy_o, 0);
        check("rst_result", result_o, 0);
        check("rst_valid", result_valid_o, 0);
        check("rst_overrun", overrun_o, 0);
        for (int k = 0; k < NT; k++) begin
            mx[k] = 0;
            mh[k] = 0;
        end
        exp_q.delete();
        stamp_q.delete();
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_coef(input int k, input logic signed [15:0] v, input bit upd);
        coef_we_i   = 1'b1;
        coef_addr_i = 3'(k);
        coef_i      = v;
        if (upd) mh[k] = v;
        @(posedge clk_i);
        #1 coef_we_i = 1'b0;
    endtask

    task automatic send_sample(input logic signed [15:0] v, input bit push);
        sample_valid_i = 1'b1;
        sample_i       = v;
        for (int k = NT - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = v;
        if (push) begin
            exp_q.push_back(model_y());
            stamp_q.push_back(cyc + 1);
        end
        @(posedge clk_i);
        #1 sample_valid_i = 1'b0;
    endtask

    task automatic strobe_dropped(input logic signed [15:0] v);
        sample_valid_i = 1'b1;
        sample_i       = v;
        @(posedge clk_i);
        #1 sample_valid_i = 1'b0;
    endtask

    task automatic wait_result();
        for (int n = 0; n < 20; n++) begin
            @(posedge clk_i);
            #1;
            if (result_valid_o) break;
        end
        if (!result_valid_o) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_result: got no result_valid_o within 20 cycles required a pulse");
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    initial begin
        rst_i          = 1'b0;
        sample_valid_i = 1'b0;
        sample_i       = 16'sd0;
        coef_we_i      = 1'b0;
        coef_addr_i    = 3'd0;
        coef_i         = 16'sd0;
        for (int k = 0; k < NT; k++) begin
            mx[k] = 0;
            mh[k] = 0;
        end
        tbl[0] = '{16'sd1, 64'sd1};
        for (int i = 1; i < 8; i++) tbl[i] = '{16'sd0, longint'(i + 1)};
        tbl[8] = '{16'sd0, 64'sd0};

        @(posedge clk_i);
        #1;
        do_reset();

        // Impulse response, table driven.
        for (int k = 0; k < NT; k++) write_coef(k, 16'(k + 1), 1'b1);
        for (int i = 0; i < 9; i++) begin
            send_sample(tbl[i].sample, 1'b1);
            check("busy_after_accept", busy_o, 1);
            wait_result();
            check("impulse", result_o, tbl[i].expected);
            @(posedge clk_i);
            #1;
            check("valid_one_cycle", result_valid_o, 0);
            check("result_hold", result_o, tbl[i].expected);
        end

        // Extremes: no wrap in the accumulator.
        for (int k = 0; k < NT; k++) write_coef(k, -16'sd32768, 1'b1);
        for (int i = 0; i < NT; i++) begin
            send_sample(-16'sd32768, 1'b1);
            wait_result();
        end
        check("extreme_neg_neg", result_o, 64'sd8589934592);
        for (int i = 0; i < NT; i++) begin
            send_sample(16'sd32767, 1'b1);
            wait_result();
        end
        check("extreme_pos_neg", result_o, -64'sd8589672448);
        idle_cycles(1);

        // Overrun: sample strobed at cycle 3 of MAC is dropped.
        check("overrun_clear", overrun_o, 0);
        send_sample(16'sd1000, 1'b1);
        idle_cycles(2);
        strobe_dropped(-16'sd5);
        check("overrun_set", overrun_o, 1);
        wait_result();
        idle_cycles(1);
        send_sample(16'sd7, 1'b1);
        wait_result();
        check("overrun_sticky", overrun_o, 1);
        idle_cycles(2);

        // Reset while idle with nonzero outputs.
        do_reset();

        // Back-to-back samples with an ignored mid-MAC coefficient write.
        for (int k = 0; k < NT; k++) write_coef(k, 16'(k - 3), 1'b1);
        send_sample(16'sd10, 1'b1);
        wait_result();
        send_sample(16'sd20, 1'b1);
        check("b2b_accept_busy", busy_o, 1);
        idle_cycles(1);
        write_coef(0, 16'sd999, 1'b0);
        wait_result();
        send_sample(16'sd30, 1'b1);
        #5;
        check("b2b_gap1", last_pulse - prev_pulse, NT + 1);
        #1;
        wait_result();
        #5;
        check("b2b_gap2", last_pulse - prev_pulse, NT + 1);
        #1;
        idle_cycles(1);

        // Reset at cycle 4 of MAC: no pulse, all-zero coefficients afterwards.
        send_sample(16'sd50, 1'b0);
        idle_cycles(3);
        do_reset();
        idle_cycles(12);
        check("post_rst_busy", busy_o, 0);
        check("post_rst_result", result_o, 0);
        send_sample(16'sd1, 1'b1);
        wait_result();
        check("zero_coef_impulse", result_o, 0);
        idle_cycles(1);

        // Coefficient write and sample in the same idle cycle.
        coef_we_i      = 1'b1;
        coef_addr_i    = 3'd0;
        coef_i         = 16'sd5;
        mh[0]          = 5;
        send_sample(16'sd3, 1'b1);
        coef_we_i      = 1'b0;
        wait_result();
        check("same_cycle_write", result_o, 64'sd15);
        idle_cycles(2);

        check("pending_results", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
